// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   RF_DATA_W / RF_NUM_REGS : default register width and register count
//   wsel_e                  : which write port, if any, updates a register this edge
//   addr_ok()               : address lies inside the file and is writable/readable
//   next_val()              : per-register write-port selection, with port 2
//                             priority and the range / hardwired-r0 masking applied
package regfile_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 16;

  typedef enum logic [1:0] {
    WSEL_NONE,
    WSEL_P1,
    WSEL_P2
  } wsel_e;

  function automatic bit addr_ok(int unsigned addr, int unsigned num_regs, bit zero_r0);
    return (addr < num_regs) && !(zero_r0 && (addr == 0));
  endfunction

  // Returns the source of a register's post-edge value rather than the value
  // itself, so the helper stays independent of the data width. Storage, the
  // bypass path and the scoreboard clear all derive from this one decision.
  function automatic wsel_e next_val(int unsigned addr,
                                     logic we1, int unsigned wa1,
                                     logic we2, int unsigned wa2,
                                     int unsigned num_regs, bit zero_r0);
    if (!addr_ok(addr, num_regs, zero_r0)) return WSEL_NONE;
    if (we2 && (wa2 == addr))              return WSEL_P2;
    if (we1 && (wa1 == addr))              return WSEL_P1;
    return WSEL_NONE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write (busy) bit per register.
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : per-register write-hit vector for this edge
//   rsv_en/addr   : mark a register as awaiting writeback
//   rd_addr1/2    : lookup addresses
//   rd_busy1/2    : registered busy state for the lookup addresses
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 0,
  parameter int ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] clr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                rd_busy1,
  output logic                rd_busy2
);

  localparam int unsigned NREG = NUM_REGS;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                busy_nxt1;
  logic                busy_nxt2;
  logic                src;

  // A reservation in the same edge as a write to that register wins.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (rsv_en && (32'(rsv_addr) == i) && addr_ok(i, NREG, ZERO_R0 != 0))
        busy_nxt[i] = 1'b1;
      else if (clr[i])
        busy_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    busy_nxt1 = 1'b0;
    busy_nxt2 = 1'b0;
    src       = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      src = (BYPASS != 0) ? busy_nxt[i] : busy[i];
      if (addr_ok(i, NREG, ZERO_R0 != 0)) begin
        if (32'(rd_addr1) == i) busy_nxt1 = src;
        if (32'(rd_addr2) == i) busy_nxt2 = src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      rd_busy1 <= 1'b0;
      rd_busy2 <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      rd_busy1 <= busy_nxt1;
      rd_busy2 <= busy_nxt2;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, two write ports (port 2 wins on
// collision), two registered read ports with optional write-to-read bypass,
// an observation copy of one register and a pending-write scoreboard.
//   clk, rst               : clock, asynchronous active-low reset
//   rd_addr1/2             : read addresses (1-cycle latency)
//   rd_data1/2, rd_busy1/2 : registered read data and busy bits
//   obs_data               : registered copy of register OBS_REG
//   we1/wa1/wd1, we2/wa2/wd2 : write ports
//   rsv_en/rsv_addr        : reserve (set busy) request
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int OBS_REG  = NUM_REGS - 1,
  parameter int BYPASS   = 0,
  parameter int ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic [DATA_W-1:0] obs_data,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  localparam int unsigned NREG    = NUM_REGS;
  localparam int unsigned OBS_IDX = OBS_REG;

  logic [DATA_W-1:0]   mem  [NUM_REGS];
  logic [DATA_W-1:0]   post [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0]   rd_nxt1;
  logic [DATA_W-1:0]   rd_nxt2;
  logic [DATA_W-1:0]   obs_nxt;
  logic [DATA_W-1:0]   src;

  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      post[i] = mem[i];
      unique case (next_val(i, we1, 32'(wa1), we2, 32'(wa2), NREG, ZERO_R0 != 0))
        WSEL_P2: begin
          post[i]   = wd2;
          wr_hit[i] = 1'b1;
        end
        WSEL_P1: begin
          post[i]   = wd1;
          wr_hit[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read ports and obs share one selection so they obey the same bypass rule;
  // out-of-range and hardwired-zero addresses fall through to '0.
  always_comb begin
    rd_nxt1 = '0;
    rd_nxt2 = '0;
    obs_nxt = '0;
    src     = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      src = (BYPASS != 0) ? post[i] : mem[i];
      if (addr_ok(i, NREG, ZERO_R0 != 0)) begin
        if (32'(rd_addr1) == i) rd_nxt1 = src;
        if (32'(rd_addr2) == i) rd_nxt2 = src;
        if (OBS_IDX == i)       obs_nxt = src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      obs_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= post[i];
      rd_data1 <= rd_nxt1;
      rd_data2 <= rd_nxt2;
      obs_data <= obs_nxt;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .BYPASS   (BYPASS),
    .ZERO_R0  (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr      (wr_hit),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_busy1 (rd_busy1),
    .rd_busy2 (rd_busy2)
  );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the datapath's 16x16 register file. Provides a configurable width and depth, two independent write ports with defined collision priority, and registered read ports with an optional write-to-read bypass. Adds a pending-write scoreboard (busy bits) so the pipeline hazard unit can detect reads of registers still awaiting writeback. Sits between the decode stage (reads and reservations) and the writeback stage (writes).

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 16, number of architectural registers (2..256)
ADDR_W, $clog2(NUM_REGS), address width (derived; do not override)
OBS_REG, NUM_REGS-1, index of the register mirrored on obs_data
BYPASS, 0, 1 = read in a write cycle returns the newly written value; 0 = returns the old value
ZERO_R0, 0, 1 = register 0 is hardwired to zero and never busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data, registered
rd_data2  out  DATA_W  read port 2 data, registered
rd_busy1  out  1  scoreboard bit for rd_addr1, registered
rd_busy2  out  1  scoreboard bit for rd_addr2, registered
obs_data  out  DATA_W  registered copy of register OBS_REG
we1  in  1  write enable, port 1
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
we2  in  1  write enable, port 2
wa2  in  ADDR_W  write address, port 2
wd2  in  DATA_W  write data, port 2
rsv_en  in  1  reserve (set busy) enable
rsv_addr  in  ADDR_W  register to mark pending

Behaviour:
- Reset (rst=0, asynchronous): every register clears to 0, every busy bit clears to 0, and rd_data1, rd_data2, rd_busy1, rd_busy2 and obs_data all go to 0. Reset held mid-operation discards all pending writes and reservations.
- Writes: on the rising edge, if weN=1 then reg[waN] <= wdN. Ports are independent; there is no global enable.
- Write collision: if we1 and we2 are both set with wa1==wa2, port 2 wins.
- Out-of-range address (index >= NUM_REGS): the write is ignored, reads return 0, rd_busy returns 0, and a reservation is ignored.
- ZERO_R0=1: writes and reservations to address 0 are ignored; reads of address 0 return 0 and busy 0.
- Reads: 1-cycle latency. rd_dataN at edge k+1 reflects rd_addrN sampled at edge k.
  - BYPASS=0: the value returned is reg[] before any write in the same edge.
  - BYPASS=1: the value returned is the post-write value, with port 2 priority applied.
- obs_data follows the same latency and BYPASS rule as the read ports, at fixed index OBS_REG.
- Scoreboard: busy[a] is set at the edge when rsv_en=1 and rsv_addr=a. It is cleared at the edge when a write (either port) targets a.
  - Reserve and write to the same address in the same edge: busy stays 1 (the new reservation wins).
  - Reserving an already-busy register keeps it busy; the scoreboard does not count reservations.
- rd_busyN: registered, 1-cycle latency, aligned with rd_dataN.
  - BYPASS=1: reflects the post-edge busy state.
  - BYPASS=0: reflects the pre-edge busy state.
- Writing a register that is not busy is legal and leaves busy at 0.

Decomposition:
- Shared package regfile_pkg: default DATA_W and NUM_REGS constants, and a function next_val(addr) encoding the two-port priority plus the ZERO_R0/range masking. The storage and read paths both use this function so bypass and storage can never disagree.
- One sub-module, regfile_scoreboard: busy-bit vector with set/clear priority logic and two registered lookup ports.

Test Plan:
- Reset: write 0xBEEF to r3, then pulse rst low for one cycle -> rd_data1 at rd_addr1=3 reads 0x0000, rd_busy1=0, obs_data=0.
- Basic latency: write r5=0x1234 via port 1, then read r5 the following cycle -> rd_data1=0x1234 exactly one edge after the address is presented.
- Collision: in the same edge, we1 r7=0xAAAA and we2 r7=0x5555 -> r7 reads 0x5555. With BYPASS=1, a read of r7 in that same edge also returns 0x5555; with BYPASS=0 it returns the prior 0x0000.
- Scoreboard: reserve r4 -> rd_busy for r4=1. A port-2 write of r4=0x0042 clears it; a later read gives 0x0042 with busy 0. Simultaneous rsv r4 and write r4 -> busy stays 1.
- Dual read/obs: preload r15=0xF00D and r1=0x0001, read both ports on r1/r15 -> rd_data1=0x0001, rd_data2=0xF00D, obs_data=0xF00D.
- Edge config (NUM_REGS=12, ZERO_R0=1): writing r0=0xFFFF and r13=0x1111 has no effect; reads of r0 and r13 return 0 with busy 0.
